// File: rtl/fetch_pipeline_unit.sv
// Purpose: instruction fetch stage feeding decode from a synchronous-read instruction ROM, with branch redirect; optional perf counters under FETCH_PERF_CNT_EN.
// Latency: 2 clk edges from address issue to instr_out/pc_out; steady-state 1 instruction per cycle; one bubble per redirect.
// Backpressure: stall holds all outputs and reissues the last address so the ROM data is still valid on release; branch_valid overrides stall.
module fetch_pipeline_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_valid,
    input  logic [6:0]  branch_target,
    output logic [6:0]  imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [6:0]  pc_out,
    output logic        valid_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] fetch_cnt,
    output logic [15:0] bubble_cnt
`endif
);

    localparam logic [31:0] NOP = 32'hE320F000;

    typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [6:0] pc_reg;
    logic [6:0] req_pc;
    logic       do_squash;
    logic       do_fill;
    logic       do_fetch;

    // Address mux: a redirect wins, a stall re-presents last cycle's address, otherwise stream.
    always_comb begin
        imem_addr = pc_reg;
        if (branch_valid) begin
            imem_addr = branch_target;
        end else if (stall) begin
            imem_addr = req_pc;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and datapath load selects; FILL ignores stall because nothing valid is in flight yet.
    always_comb begin
        state_nxt = state;
        do_squash = 1'b0;
        do_fill   = 1'b0;
        do_fetch  = 1'b0;
        if (branch_valid) begin
            do_squash = 1'b1;
            state_nxt = RUN;
        end else begin
            case (state)
                FILL: begin
                    do_fill   = 1'b1;
                    state_nxt = RUN;
                end
                RUN: begin
                    do_fetch = !stall;
                end
                default: state_nxt = FILL;
            endcase
        end
    end

    // Fetch datapath: PCs and the registered decode-side outputs; PC arithmetic wraps at 128.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg    <= 7'd0;
            req_pc    <= 7'd0;
            instr_out <= NOP;
            pc_out    <= 7'd0;
            valid_out <= 1'b0;
        end else if (do_squash) begin
            instr_out <= NOP;
            valid_out <= 1'b0;
            req_pc    <= branch_target;
            pc_reg    <= branch_target + 7'd1;
        end else if (do_fill) begin
            instr_out <= NOP;
            valid_out <= 1'b0;
            pc_out    <= 7'd0;
            req_pc    <= pc_reg;
            pc_reg    <= pc_reg + 7'd1;
        end else if (do_fetch) begin
            instr_out <= imem_rdata;
            pc_out    <= req_pc;
            valid_out <= 1'b1;
            req_pc    <= pc_reg;
            pc_reg    <= pc_reg + 7'd1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating counters of delivered instructions and redirect bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt  <= 16'd0;
            bubble_cnt <= 16'd0;
        end else begin
            if (do_fetch && fetch_cnt != 16'hFFFF) begin
                fetch_cnt <= fetch_cnt + 16'd1;
            end
            if (do_squash && bubble_cnt != 16'hFFFF) begin
                bubble_cnt <= bubble_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
